vga_frota_scheduler: RTL and testbench

- Frame-level controller for the fleet overlay of the VGA board view.
- During each vertical blank it fetches the five ship records from the game-state position memory over a req/ack read port.
- It validates each record, converts cell coordinates to pixel rectangles in a shadow bank, and swaps the shadow bank into the active bank before the next visible frame.
- In the visible area it arbitrates the five ship layers per pixel and drives registered 1-bit RGB.

---
 rtl/vga_frota_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_vga_frota_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frota_scheduler.sv
// -----------------------------------------------------------------------------
// vga_frota_scheduler
//
// Frame-level controller for the fleet overlay of the VGA board view.
// During vertical blank it reads the five ship records from the game-state
// position memory, validates them, converts cell coordinates to pixel
// rectangles in a shadow bank and swaps that bank into the active bank. In the
// visible area it picks, per pixel, the lowest-index ship covering the pixel
// and drives registered 1-bit RGB plus the id of the winning ship.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_start         one-cycle pulse at the start of vertical blank
//   vblank              high throughout vertical blank
//   areaAtiva           current pixel is visible
//   linha, coluna       horizontal / vertical pixel coordinate (10 bits)
//   rd_req, rd_addr     read request and ship index to the position memory
//   rd_ack, rd_data     read data valid and 16-bit ship record
//                       [3:0] X, [7:4] Y, [10:8] length, [11] vertical,
//                       [12] valid, [15:13] ignored
//   rgb_r/g/b           registered colour of the current pixel
//   navio_id            ship drawn at the current pixel, 7 = none
//   busy                fetch in progress
//   overrun             sticky: vblank ended before the bank swap
//   erro_registro       one-cycle pulse per rejected record with valid=1
// -----------------------------------------------------------------------------
module vga_frota_scheduler #(
   parameter int N_NAVIOS = 5,
   parameter int ORIGEM_X = 16,
   parameter int ORIGEM_Y = 16,
   parameter int PASSO_X  = 62,
   parameter int PASSO_Y  = 57,
   parameter int LARGURA  = 54,
   parameter int ALTURA   = 49
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        vblank,
   input  logic        areaAtiva,
   input  logic [9:0]  linha,
   input  logic [9:0]  coluna,
   output logic        rd_req,
   output logic [2:0]  rd_addr,
   input  logic        rd_ack,
   input  logic [15:0] rd_data,
   output logic        rgb_r,
   output logic        rgb_g,
   output logic        rgb_b,
   output logic [2:0]  navio_id,
   output logic        busy,
   output logic        overrun,
   output logic        erro_registro
);

   localparam int         MAX_CELULAS = 5;
   localparam logic [2:0] ID_NENHUM   = 3'd7;
   localparam logic [2:0] ULTIMO      = 3'(N_NAVIOS - 1);

   typedef enum logic [1:0] {OCIOSO, PEDE, CALCULA, TROCA} estado_t;

   // One bank entry: a ship already converted to pixel space.
   typedef struct packed {
      logic       valido;
      logic       vertical;
      logic [2:0] comp;
      logic [9:0] esq;
      logic [9:0] base;
   } navio_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   estado_t     estado_q;
   logic [2:0]  idx_q;
   logic [12:0] reg_q;          // captured record, ignored top bits dropped
   logic        rd_req_q;
   logic [2:0]  rd_addr_q;
   logic        busy_q;
   logic        overrun_q;
   logic        erro_q;
   navio_t      sombra_q [N_NAVIOS];
   navio_t      ativo_q  [N_NAVIOS];
   logic [2:0]  rgb_q;
   logic [2:0]  id_q;

   // Bits [15:13] of the record carry no meaning for this block.
   logic unused_rd_data;
   assign unused_rd_data = ^rd_data[15:13];

   // ---------------------------------------------------------------------------
   // Record decode and validation (consumed in CALCULA)
   // ---------------------------------------------------------------------------
   logic [3:0] rec_x;
   logic [3:0] rec_y;
   logic [2:0] rec_comp;
   logic       rec_vert;
   logic       rec_valido;
   logic [4:0] fim_x;
   logic [4:0] fim_y;
   logic       rejeita_d;
   logic [9:0] esq_d;
   logic [9:0] base_d;
   navio_t     entrada_d;

   // NOTE: every signal written in an always_comb gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      rec_x      = reg_q[3:0];
      rec_y      = reg_q[7:4];
      rec_comp   = reg_q[10:8];
      rec_vert   = reg_q[11];
      rec_valido = reg_q[12];

      // Last occupied cell is X+len-1 <= 8, i.e. X+len <= 9.
      fim_x = {1'b0, rec_x} + {2'b00, rec_comp};
      fim_y = {1'b0, rec_y} + {2'b00, rec_comp};

      rejeita_d = 1'b0;
      if (!rec_valido)                               rejeita_d = 1'b1;
      if (rec_x == 4'd0 || rec_x > 4'd8)             rejeita_d = 1'b1;
      if (rec_y == 4'd0 || rec_y > 4'd8)             rejeita_d = 1'b1;
      if (rec_comp == 3'd0 || rec_comp > 3'd5)       rejeita_d = 1'b1;
      if (rec_vert ? (fim_y > 5'd9) : (fim_x > 5'd9)) rejeita_d = 1'b1;

      // Only used when accepted, so X-1 and Y-1 never wrap.
      esq_d  = 10'(ORIGEM_X) + ({6'b0, rec_x} - 10'd1) * 10'(PASSO_X);
      base_d = 10'(ORIGEM_Y) + ({6'b0, rec_y} - 10'd1) * 10'(PASSO_Y);

      entrada_d.valido   = 1'b1;
      entrada_d.vertical = rec_vert;
      entrada_d.comp     = rec_comp;
      entrada_d.esq      = esq_d;
      entrada_d.base     = base_d;
   end

   // ---------------------------------------------------------------------------
   // Fetch / swap FSM
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= OCIOSO;
         idx_q     <= '0;
         reg_q     <= '0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         erro_q    <= 1'b0;
         // NOTE: both banks are small register arrays (not RAM) and must read
         // as invalid straight out of reset, so they are reset in full.
         for (int i = 0; i < N_NAVIOS; i++) begin
            sombra_q[i] <= '0;
            ativo_q[i]  <= '0;
         end
      end else begin
         erro_q <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               if (frame_start) begin
                  estado_q  <= PEDE;
                  idx_q     <= '0;
                  rd_req_q  <= 1'b1;
                  rd_addr_q <= '0;
                  busy_q    <= 1'b1;
                  for (int i = 0; i < N_NAVIOS; i++) begin
                     sombra_q[i].valido <= 1'b0;
                  end
               end
            end

            PEDE: begin
               if (!vblank) begin
                  // Blank ended mid-fetch: abandon the frame, active bank kept.
                  overrun_q <= 1'b1;
                  busy_q    <= 1'b0;
                  rd_req_q  <= 1'b0;
                  estado_q  <= OCIOSO;
               end else if (rd_req_q && rd_ack) begin
                  reg_q    <= rd_data[12:0];
                  rd_req_q <= 1'b0;
                  estado_q <= CALCULA;
               end
            end

            CALCULA: begin
               if (!vblank) begin
                  overrun_q <= 1'b1;
                  busy_q    <= 1'b0;
                  estado_q  <= OCIOSO;
               end else begin
                  if (!rejeita_d) begin
                     sombra_q[idx_q] <= entrada_d;
                  end
                  // valid=0 records are skipped silently.
                  erro_q <= rejeita_d && rec_valido;
                  if (idx_q < ULTIMO) begin
                     idx_q     <= idx_q + 3'd1;
                     rd_addr_q <= idx_q + 3'd1;
                     rd_req_q  <= 1'b1;
                     estado_q  <= PEDE;
                  end else begin
                     estado_q <= TROCA;
                  end
               end
            end

            TROCA: begin
               if (vblank) begin
                  for (int i = 0; i < N_NAVIOS; i++) begin
                     ativo_q[i] <= sombra_q[i];
                  end
               end else begin
                  overrun_q <= 1'b1;
               end
               busy_q   <= 1'b0;
               estado_q <= OCIOSO;
            end

            default: estado_q <= OCIOSO;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Pixel path: reads the active bank only
   // ---------------------------------------------------------------------------
   // True when (px, py) lies strictly inside one of the ship's cells; the
   // pitch is larger than the cell size, so the gaps are never covered.
   function automatic logic cobre_navio(input navio_t n,
                                        input logic [9:0] px,
                                        input logic [9:0] py);
      logic       hit;
      logic [9:0] x0;
      logic [9:0] y0;
      hit = 1'b0;
      for (int k = 0; k < MAX_CELULAS; k++) begin
         x0 = n.vertical ? n.esq : n.esq + 10'(k * PASSO_X);
         y0 = n.vertical ? n.base + 10'(k * PASSO_Y) : n.base;
         if (n.valido && (k < int'(n.comp)) &&
             (px > x0) && (px < x0 + 10'(LARGURA)) &&
             (py > y0) && (py < y0 + 10'(ALTURA))) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   function automatic logic [2:0] cor(input logic [2:0] id);
      logic [2:0] c;
      case (id)
         3'd0:    c = 3'b010;  // submarino: green
         3'd1:    c = 3'b100;  // cruzador: red
         3'd2:    c = 3'b110;  // hidroaviao: yellow
         3'd3:    c = 3'b101;  // encouracado: violet
         3'd4:    c = 3'b011;  // porta-avioes: cyan
         default: c = 3'b000;
      endcase
      return c;
   endfunction

   logic [N_NAVIOS-1:0] cobre;
   logic [2:0]          vencedor;

   always_comb begin
      cobre    = '0;
      vencedor = ID_NENHUM;
      for (int i = 0; i < N_NAVIOS; i++) begin
         cobre[i] = cobre_navio(ativo_q[i], linha, coluna);
      end
      // Scan from the top so the lowest covering index is written last.
      for (int i = N_NAVIOS - 1; i >= 0; i--) begin
         if (cobre[i]) vencedor = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= 3'b000;
         id_q  <= ID_NENHUM;
      end else if (areaAtiva && vencedor != ID_NENHUM) begin
         rgb_q <= cor(vencedor);
         id_q  <= vencedor;
      end else begin
         rgb_q <= 3'b000;
         id_q  <= ID_NENHUM;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign rd_req        = rd_req_q;
   assign rd_addr       = rd_addr_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;
   assign erro_registro = erro_q;
   assign rgb_r         = rgb_q[2];
   assign rgb_g         = rgb_q[1];
   assign rgb_b         = rgb_q[0];
   assign navio_id      = id_q;

endmodule

// File: tb/tb_vga_frota_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_frota_scheduler
//
// Self-checking bench for vga_frota_scheduler: fixed vector tables for the
// directed frames, hand-written sequences for overrun and mid-fetch reset, and
// randomized frames checked against a cell-level model of the board.
// -----------------------------------------------------------------------------
module tb_vga_frota_scheduler;

   localparam int N        = 5;
   localparam int ORIGEM_X = 16;
   localparam int ORIGEM_Y = 16;
   localparam int PASSO_X  = 62;
   localparam int PASSO_Y  = 57;
   localparam int LARGURA  = 54;
   localparam int ALTURA   = 49;

   typedef logic [15:0] recs_t [N];

   typedef struct {
      int         fase;
      int         l;
      int         c;
      bit         a;
      logic [2:0] rgb;
      logic [2:0] id;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        vblank = 1'b0;
   logic        areaAtiva = 1'b0;
   logic [9:0]  linha = '0;
   logic [9:0]  coluna = '0;
   logic        rd_req;
   logic [2:0]  rd_addr;
   logic        rd_ack = 1'b0;
   logic [15:0] rd_data = '0;
   logic        rgb_r, rgb_g, rgb_b;
   logic [2:0]  navio_id;
   logic        busy, overrun, erro_registro;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the records currently on screen and whether each is
   // drawable, plus the expected sticky overrun flag.
   logic [15:0] mdl_rec [N];
   bit          mdl_ok  [N];
   bit          mdl_overrun;

   vec_t tabela[$];

   always #5 clk = ~clk;

   vga_frota_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .vblank        (vblank),
      .areaAtiva     (areaAtiva),
      .linha         (linha),
      .coluna        (coluna),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_ack        (rd_ack),
      .rd_data       (rd_data),
      .rgb_r         (rgb_r),
      .rgb_g         (rgb_g),
      .rgb_b         (rgb_b),
      .navio_id      (navio_id),
      .busy          (busy),
      .overrun       (overrun),
      .erro_registro (erro_registro)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(input int x, input int y, input int len,
                                      input int vert, input int v);
      return {3'b000, 1'(v), 1'(vert), 3'(len), 4'(y), 4'(x)};
   endfunction

   function automatic vec_t mkv(input int f, input int l, input int c, input bit a,
                                input logic [2:0] rgb, input logic [2:0] id);
      vec_t v;
      v.fase = f; v.l = l; v.c = c; v.a = a; v.rgb = rgb; v.id = id;
      return v;
   endfunction

   // Acceptance rules stated on the record fields.
   function automatic bit aceita(input logic [15:0] r);
      int x, y, l;
      x = int'(r[3:0]);
      y = int'(r[7:4]);
      l = int'(r[10:8]);
      if (!r[12]) return 0;
      if (x < 1 || x > 8 || y < 1 || y > 8) return 0;
      if (l < 1 || l > 5) return 0;
      if (r[11] ? (y + l - 1 > 8) : (x + l - 1 > 8)) return 0;
      return 1;
   endfunction

   function automatic logic [2:0] cor_esperada(input int i);
      case (i)
         0: return 3'b010;
         1: return 3'b100;
         2: return 3'b110;
         3: return 3'b101;
         4: return 3'b011;
         default: return 3'b000;
      endcase
   endfunction

   // Walks the cells of each drawn ship in board coordinates; first hit wins.
   task automatic modelo_pixel(input int l, input int c, input bit a,
                               output logic [2:0] rgb, output logic [2:0] id);
      int  x, y, len, cx, cy, x0, y0;
      bit  achou;
      rgb = 3'b000;
      id  = 3'd7;
      achou = 0;
      if (a) begin
         for (int i = 0; i < N; i++) begin
            if (!achou && mdl_ok[i]) begin
               x   = int'(mdl_rec[i][3:0]);
               y   = int'(mdl_rec[i][7:4]);
               len = int'(mdl_rec[i][10:8]);
               for (int k = 0; k < len; k++) begin
                  cx = mdl_rec[i][11] ? x : x + k;
                  cy = mdl_rec[i][11] ? y + k : y;
                  x0 = ORIGEM_X + (cx - 1) * PASSO_X;
                  y0 = ORIGEM_Y + (cy - 1) * PASSO_Y;
                  if (!achou && l > x0 && l < x0 + LARGURA && c > y0 && c < y0 + ALTURA) begin
                     achou = 1;
                     id    = 3'(i);
                     rgb   = cor_esperada(i);
                  end
               end
            end
         end
      end
   endtask

   task automatic check_pixel(input string nm, input int l, input int c, input bit a,
                              input logic [2:0] exp_rgb, input logic [2:0] exp_id);
      @(negedge clk);
      linha     = 10'(l);
      coluna    = 10'(c);
      areaAtiva = a;
      @(posedge clk);
      #1;
      check({nm, " rgb"}, {29'd0, rgb_r, rgb_g, rgb_b}, {29'd0, exp_rgb});
      check({nm, " id"},  {29'd0, navio_id}, {29'd0, exp_id});
   endtask

   task automatic aplica_fase(input int f, input string nm);
      foreach (tabela[i]) begin
         if (tabela[i].fase == f)
            check_pixel($sformatf("%s v%0d", nm, i), tabela[i].l, tabela[i].c,
                        tabela[i].a, tabela[i].rgb, tabela[i].id);
      end
   endtask

   // One vertical blank: serves reads with the given ack delay; when corte>=0
   // vblank is dropped as soon as that index is requested.
   task automatic quadro(input string nm, input recs_t recs, input int atraso, input int corte);
      int n_tx, n_err, exp_tx, exp_err, ciclos, espera;
      bit fim;
      n_tx = 0; n_err = 0; ciclos = 0; espera = 0; fim = 0;
      @(negedge clk);
      vblank = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      while (!fim && ciclos < 1000) begin
         if (erro_registro) n_err++;
         if (!busy) begin
            fim = 1;
         end else begin
            rd_ack = 1'b0;
            if (rd_req) begin
               if (corte >= 0 && int'(rd_addr) == corte) begin
                  vblank = 1'b0;
               end else if (espera >= atraso) begin
                  check($sformatf("%s addr", nm), {29'd0, rd_addr}, 32'(n_tx));
                  rd_ack  = 1'b1;
                  rd_data = (int'(rd_addr) < N) ? recs[rd_addr] : 16'h0;
                  n_tx++;
                  espera = 0;
               end else begin
                  espera++;
               end
            end
         end
         if (!fim) begin
            @(negedge clk);
            ciclos++;
         end
      end
      rd_ack = 1'b0;
      vblank = 1'b0;

      exp_tx  = (corte >= 0) ? corte : N;
      exp_err = 0;
      for (int i = 0; i < exp_tx; i++)
         if (recs[i][12] && !aceita(recs[i])) exp_err++;
      check({nm, " done"}, {31'd0, fim}, 32'd1);
      check({nm, " tx"},   32'(n_tx), 32'(exp_tx));
      check({nm, " erro"}, 32'(n_err), 32'(exp_err));
      check({nm, " busy"}, {31'd0, busy}, 32'd0);
      if (corte < 0) begin
         for (int i = 0; i < N; i++) begin
            mdl_rec[i] = recs[i];
            mdl_ok[i]  = aceita(recs[i]);
         end
      end else begin
         mdl_overrun = 1;
      end
      check({nm, " overrun"}, {31'd0, overrun}, {31'd0, mdl_overrun});
   endtask

   initial begin
      recs_t       r;
      logic [2:0]  er, ei;
      int          l, c, cx, cy;
      bit          a;

      // Directed pixel vectors, per frame phase.
      // 1: all records invalid
      tabela.push_back(mkv(1,  17,  17, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(1, 200, 200, 1, 3'b000, 3'd7));
      // 2: ship 0 at X1 Y1, length 1, horizontal
      tabela.push_back(mkv(2,  17,  17, 1, 3'b010, 3'd0));
      tabela.push_back(mkv(2,  16,  17, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(2,  70,  17, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(2,  69,  64, 1, 3'b010, 3'd0));
      tabela.push_back(mkv(2,  17,  65, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(2,  17,  16, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(2,  30,  30, 0, 3'b000, 3'd7));
      // 3: ship 4 at X2 Y3, length 4, horizontal
      tabela.push_back(mkv(3,  79, 131, 1, 3'b011, 3'd4));
      tabela.push_back(mkv(3, 131, 178, 1, 3'b011, 3'd4));
      tabela.push_back(mkv(3, 141, 150, 1, 3'b011, 3'd4));
      tabela.push_back(mkv(3, 317, 178, 1, 3'b011, 3'd4));
      tabela.push_back(mkv(3, 135, 150, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(3, 132, 150, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(3, 318, 150, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(3, 100, 130, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(3, 100, 179, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(3,  17,  17, 1, 3'b000, 3'd7));
      // 4: ships 0 and 1 overlap at (3,3); ships 2 and 3 rejected
      tabela.push_back(mkv(4, 141, 131, 1, 3'b010, 3'd0));
      tabela.push_back(mkv(4, 193, 178, 1, 3'b010, 3'd0));
      tabela.push_back(mkv(4, 100, 150, 1, 3'b100, 3'd1));
      tabela.push_back(mkv(4, 210, 150, 1, 3'b100, 3'd1));
      tabela.push_back(mkv(4, 256, 150, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(4, 135, 150, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(4, 389, 245, 1, 3'b000, 3'd7));
      // 5: aborted frame that would have placed ship 0 at X8 Y8
      tabela.push_back(mkv(5, 451, 416, 1, 3'b000, 3'd7));
      // 6: after mid-fetch reset
      tabela.push_back(mkv(6, 141, 150, 1, 3'b000, 3'd7));
      tabela.push_back(mkv(6,  17,  17, 1, 3'b000, 3'd7));

      for (int i = 0; i < N; i++) begin
         mdl_rec[i] = '0;
         mdl_ok[i]  = 0;
      end
      mdl_overrun = 0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst rd_req",  {31'd0, rd_req}, 32'd0);
      check("rst rd_addr", {29'd0, rd_addr}, 32'd0);
      check("rst busy",    {31'd0, busy}, 32'd0);
      check("rst overrun", {31'd0, overrun}, 32'd0);
      check("rst erro",    {31'd0, erro_registro}, 32'd0);
      check("rst id",      {29'd0, navio_id}, 32'd7);
      check("rst rgb",     {29'd0, rgb_r, rgb_g, rgb_b}, 32'd0);
      rst_n = 1'b1;

      // Phase 1: all invalid
      r = '{default: 16'h0000};
      quadro("f1", r, 0, -1);
      aplica_fase(1, "f1");

      // Phase 2
      r = '{default: 16'h0000};
      r[0] = mk(1, 1, 1, 0, 1);
      quadro("f2", r, 1, -1);
      aplica_fase(2, "f2");

      // Phase 3
      r = '{default: 16'h0000};
      r[4] = mk(2, 3, 4, 0, 1);
      quadro("f3", r, 0, -1);
      aplica_fase(3, "f3");

      // Phase 4: overlap and rejections
      r = '{default: 16'h0000};
      r[0] = mk(3, 3, 1, 0, 1);
      r[1] = mk(2, 3, 3, 0, 1);
      r[2] = mk(7, 5, 3, 0, 1);
      r[3] = mk(0, 6, 1, 0, 1);
      quadro("f4", r, 2, -1);
      aplica_fase(4, "f4");

      // Phase 5: slow memory, vblank lost during index 3
      r = '{default: mk(1, 1, 1, 0, 1)};
      r[0] = mk(8, 8, 1, 0, 1);
      quadro("f5", r, 10, 3);
      aplica_fase(5, "f5");
      aplica_fase(4, "f5 keep");

      // Phase 6: asynchronous reset while in PEDE
      @(negedge clk);
      linha = 10'd141; coluna = 10'd150; areaAtiva = 1'b1;
      vblank = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("f6 pede rd_req", {31'd0, rd_req}, 32'd1);
      check("f6 pede id",     {29'd0, navio_id}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("f6 rst rd_req",  {31'd0, rd_req}, 32'd0);
      check("f6 rst busy",    {31'd0, busy}, 32'd0);
      check("f6 rst overrun", {31'd0, overrun}, 32'd0);
      check("f6 rst id",      {29'd0, navio_id}, 32'd7);
      check("f6 rst rgb",     {29'd0, rgb_r, rgb_g, rgb_b}, 32'd0);
      check("f6 rst addr",    {29'd0, rd_addr}, 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      vblank = 1'b0;
      for (int i = 0; i < N; i++) begin
         mdl_rec[i] = '0;
         mdl_ok[i]  = 0;
      end
      mdl_overrun = 0;
      repeat (3) @(negedge clk);
      check("f6 idle rd_req", {31'd0, rd_req}, 32'd0);
      aplica_fase(6, "f6");
      r = '{default: 16'h0000};
      r[0] = mk(1, 1, 1, 0, 1);
      quadro("f6 refetch", r, 0, -1);
      aplica_fase(2, "f6 drawn");

      // Randomized frames against the model
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < N; i++) begin
            r[i] = {3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 6)),
                    4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9))};
         end
         if (f == 5) quadro($sformatf("rnd%0d", f), r, 2, int'($urandom_range(1, 4)));
         else        quadro($sformatf("rnd%0d", f), r, int'($urandom_range(0, 3)), -1);
         for (int j = 0; j < 30; j++) begin
            if (j % 2 == 0) begin
               l = int'($urandom_range(0, 560));
               c = int'($urandom_range(0, 520));
            end else begin
               cx = int'($urandom_range(1, 8));
               cy = int'($urandom_range(1, 8));
               l  = ORIGEM_X + (cx - 1) * PASSO_X + int'($urandom_range(0, LARGURA));
               c  = ORIGEM_Y + (cy - 1) * PASSO_Y + int'($urandom_range(0, ALTURA));
            end
            a = ($urandom_range(0, 7) != 0);
            modelo_pixel(l, c, a, er, ei);
            check_pixel($sformatf("rnd%0d px%0d (%0d,%0d)", f, j, l, c), l, c, a, er, ei);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
